// File: rtl/decode_stage_pkg.sv
// Shared decode types for the front end.
// Contents: major-opcode constants, opcode class enum, arithmetic-kind enum,
// stage occupancy states, the decoded-entry struct and small helper
// functions mapping funct3 to an arithmetic kind.
package opcode_type;

    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // invalid must stay ordinal 0 so an all-zero entry reads as invalid
    typedef enum logic [3:0] {
        invalid, lui_type, auipc_type, jal_type, jalr_type, branch_type,
        load_type, store_type, imm_arith_type, reg_arith_type, fence_type,
        system_type
    } opcode_t;

    // M-extension kinds sit after rak_and so earlier ordinals never move
    typedef enum logic [4:0] {
        rak_invalid, rak_add, rak_sub, rak_sll, rak_slt, rak_sltu, rak_xor,
        rak_srl, rak_sra, rak_or, rak_and,
        rak_mul, rak_mulh, rak_mulhsu, rak_mulhu, rak_div, rak_divu,
        rak_rem, rak_remu
    } reg_arith_kind_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_state_t;

    // imm is always carried at full width; the stage truncates to XLEN
    typedef struct packed {
        opcode_t             opcode;
        reg_arith_kind_t     rak;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [MAX_XLEN-1:0] imm;
        logic                word;
        logic                illegal;
    } decoded_t;

    // alt selects sub/sra (instr[30]) for the funct3 codes that have one
    function automatic reg_arith_kind_t base_rak(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? rak_sub : rak_add;
            3'b001:  return rak_sll;
            3'b010:  return rak_slt;
            3'b011:  return rak_sltu;
            3'b100:  return rak_xor;
            3'b101:  return alt ? rak_sra : rak_srl;
            3'b110:  return rak_or;
            default: return rak_and;
        endcase
    endfunction

    function automatic reg_arith_kind_t m_rak(input logic [2:0] f3);
        case (f3)
            3'b000:  return rak_mul;
            3'b001:  return rak_mulh;
            3'b010:  return rak_mulhsu;
            3'b011:  return rak_mulhu;
            3'b100:  return rak_div;
            3'b101:  return rak_divu;
            3'b110:  return rak_rem;
            default: return rak_remu;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32/RV64 instruction decoder.
// Ports: i_instr (raw 32-bit instruction) -> o_dec (decoded_t). Any
// encoding not legal for the configured XLEN/ENABLE_M produces an
// all-zero entry with illegal=1 (opcode reads as invalid).
module decode_comb
    import opcode_type::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input  logic [31:0] i_instr,
    output decoded_t    o_dec
);

    logic [6:0]          w_opc;
    logic [2:0]          w_f3;
    logic [6:0]          w_f7;
    logic                w_rv64;
    logic                w_m;
    logic [MAX_XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    decoded_t            w_dec;
    logic                w_ok;

    assign w_opc  = i_instr[6:0];
    assign w_f3   = i_instr[14:12];
    assign w_f7   = i_instr[31:25];
    assign w_rv64 = (XLEN == 64);
    assign w_m    = (ENABLE_M != 0);

    assign w_imm_i = {{52{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{52{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{51{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {{32{i_instr[31]}}, i_instr[31:12], 12'b0};
    assign w_imm_j = {{43{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        w_dec = '0;
        w_ok  = 1'b1;
        case (w_opc)
            OPC_LUI: begin
                w_dec.opcode = lui_type;   w_dec.rd = i_instr[11:7]; w_dec.imm = w_imm_u;
            end
            OPC_AUIPC: begin
                w_dec.opcode = auipc_type; w_dec.rd = i_instr[11:7]; w_dec.imm = w_imm_u;
            end
            OPC_JAL: begin
                w_dec.opcode = jal_type;   w_dec.rd = i_instr[11:7]; w_dec.imm = w_imm_j;
            end
            OPC_JALR, OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM, OPC_OP_IMM, OPC_OP_IMM_32: begin
                w_dec.rd = i_instr[11:7]; w_dec.rs1 = i_instr[19:15];
                w_dec.funct3 = w_f3;      w_dec.imm = w_imm_i;
                case (w_opc)
                    OPC_JALR: begin
                        w_dec.opcode = jalr_type; w_ok = (w_f3 == 3'b000);
                    end
                    OPC_LOAD: begin
                        w_dec.opcode = load_type;
                        // ld/lwu exist only on RV64
                        w_ok = (w_f3 != 3'b111) && (w_rv64 || (w_f3 != 3'b011 && w_f3 != 3'b110));
                    end
                    OPC_MISC_MEM: w_dec.opcode = fence_type;
                    OPC_SYSTEM:   w_dec.opcode = system_type;
                    OPC_OP_IMM: begin
                        w_dec.opcode = imm_arith_type;
                        w_dec.rak    = base_rak(w_f3, (w_f3 == 3'b101) && i_instr[30]);
                        // shamt[5] (instr[25]) is only meaningful on RV64
                        if (w_f3 == 3'b001)
                            w_ok = (i_instr[31:26] == 6'b0) && (w_rv64 || !i_instr[25]);
                        else if (w_f3 == 3'b101)
                            w_ok = (i_instr[31:26] == 6'b000000 || i_instr[31:26] == 6'b010000)
                                   && (w_rv64 || !i_instr[25]);
                    end
                    default: begin
                        w_dec.opcode = imm_arith_type;
                        w_dec.word   = 1'b1;
                        w_dec.rak    = base_rak(w_f3, (w_f3 == 3'b101) && i_instr[30]);
                        case (w_f3)
                            3'b000:  w_ok = w_rv64;
                            3'b001:  w_ok = w_rv64 && (w_f7 == 7'b0000000);
                            3'b101:  w_ok = w_rv64 && (w_f7 == 7'b0000000 || w_f7 == 7'b0100000);
                            default: w_ok = 1'b0;
                        endcase
                    end
                endcase
            end
            OPC_STORE, OPC_BRANCH: begin
                w_dec.rs1 = i_instr[19:15]; w_dec.rs2 = i_instr[24:20]; w_dec.funct3 = w_f3;
                if (w_opc == OPC_STORE) begin
                    w_dec.opcode = store_type; w_dec.imm = w_imm_s;
                    w_ok = !w_f3[2] && (w_rv64 || w_f3 != 3'b011);
                end else begin
                    w_dec.opcode = branch_type; w_dec.imm = w_imm_b;
                    w_ok = (w_f3[2:1] != 2'b01);
                end
            end
            OPC_OP, OPC_OP_32: begin
                w_dec.opcode = reg_arith_type;
                w_dec.rd  = i_instr[11:7]; w_dec.rs1 = i_instr[19:15];
                w_dec.rs2 = i_instr[24:20]; w_dec.funct3 = w_f3;
                w_dec.word = (w_opc == OPC_OP_32);
                if (w_f7 == 7'b0000001) begin
                    w_dec.rak = m_rak(w_f3);
                    w_ok = w_m;
                end else if (w_f7 == 7'b0000000) begin
                    w_dec.rak = base_rak(w_f3, 1'b0);
                end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    w_dec.rak = base_rak(w_f3, 1'b1);
                end else begin
                    w_ok = 1'b0;
                end
                // the *W group is RV64 only and lacks slt/sltu/xor/or/and and mulh*
                if (w_opc == OPC_OP_32)
                    w_ok = w_ok && w_rv64 && ((w_f7 == 7'b0000001) ?
                           (w_f3 == 3'b000 || w_f3[2]) :
                           (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b101));
            end
            default: w_ok = 1'b0;
        endcase

        o_dec = '0;
        o_dec.illegal = 1'b1;
        if (w_ok)
            o_dec = w_dec;
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage with a two-entry (main + skid) output buffer.
// Ports: clk/rst (async active-high), flush; upstream in_valid/in_ready/
// in_instr/in_pc; downstream out_valid/out_ready and the decoded fields
// out_opcode, out_rak, out_rd/rs1/rs2, out_funct3, out_imm, out_pc,
// out_word, out_illegal. in_ready is registered so it never depends
// combinationally on out_ready.
module decode_stage
    import opcode_type::*;
#(
    parameter int XLEN     = 32,
    parameter int ENABLE_M = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output opcode_t         out_opcode,
    output reg_arith_kind_t out_rak,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_word,
    output logic            out_illegal
);

    typedef struct packed {
        opcode_t         opcode;
        reg_arith_kind_t rak;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            word;
        logic            illegal;
    } entry_t;

    decoded_t     w_dec;
    entry_t       w_new;
    entry_t       r_main, w_main_next;
    entry_t       r_skid, w_skid_next;
    stage_state_t r_state, w_state_next;
    logic         r_in_ready;
    logic         w_push, w_pop;

    decode_comb #(.XLEN(XLEN), .ENABLE_M(ENABLE_M)) u_decode_comb (
        .i_instr (in_instr),
        .o_dec   (w_dec)
    );

    // upper immediate bits are pure sign copies on a narrow datapath
    if (XLEN < MAX_XLEN) begin : g_narrow
        logic w_imm_unused;
        assign w_imm_unused = ^w_dec.imm[MAX_XLEN-1:XLEN];
    end

    always_comb begin
        w_new         = '0;
        w_new.opcode  = w_dec.opcode;
        w_new.rak     = w_dec.rak;
        w_new.rd      = w_dec.rd;
        w_new.rs1     = w_dec.rs1;
        w_new.rs2     = w_dec.rs2;
        w_new.funct3  = w_dec.funct3;
        w_new.imm     = w_dec.imm[XLEN-1:0];
        w_new.pc      = in_pc;
        w_new.word    = w_dec.word;
        w_new.illegal = w_dec.illegal;
    end

    assign w_push    = in_valid && r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign w_pop     = out_valid && out_ready;
    assign in_ready  = r_in_ready;

    // main always holds the oldest entry; skid only fills when main stalls
    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) begin
                    w_state_next = ST_ONE;
                    w_main_next  = w_new;
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        w_main_next = w_new;
                    end else if (w_push) begin
                        w_state_next = ST_TWO;
                        w_skid_next  = w_new;
                    end else if (w_pop) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO: if (w_pop) begin
                    w_state_next = ST_ONE;
                    w_main_next  = r_skid;
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next != ST_TWO);
            r_main     <= w_main_next;
            r_skid     <= w_skid_next;
        end
    end

    assign out_opcode  = r_main.opcode;
    assign out_rak     = r_main.rak;
    assign out_rd      = r_main.rd;
    assign out_rs1     = r_main.rs1;
    assign out_rs2     = r_main.rs2;
    assign out_funct3  = r_main.funct3;
    assign out_imm     = r_main.imm;
    assign out_pc      = r_main.pc;
    assign out_word    = r_main.word;
    assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: instance A (XLEN=32, ENABLE_M=1) and instance B
// (XLEN=64, ENABLE_M=0). Expected entries are queued at handshake time and
// popped/compared by per-instance monitors on the falling edge.
module tb_decode_stage;
    import opcode_type::*;

    typedef struct {
        opcode_t         op;
        reg_arith_kind_t rak;
        logic [4:0]      rd, rs1, rs2;
        logic [2:0]      f3;
        logic [63:0]     imm;
        logic [63:0]     pc;
        logic            word;
        logic            ill;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;
    exp_t a_q[$];
    exp_t b_q[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_instr, a_in_pc, a_out_imm, a_out_pc;
    opcode_t a_out_opcode;
    reg_arith_kind_t a_out_rak;
    logic [4:0] a_out_rd, a_out_rs1, a_out_rs2;
    logic [2:0] a_out_funct3;
    logic a_out_word, a_out_illegal;

    logic b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_instr;
    logic [63:0] b_in_pc, b_out_imm, b_out_pc;
    opcode_t b_out_opcode;
    reg_arith_kind_t b_out_rak;
    logic [4:0] b_out_rd, b_out_rs1, b_out_rs2;
    logic [2:0] b_out_funct3;
    logic b_out_word, b_out_illegal;

    decode_stage #(.XLEN(32), .ENABLE_M(1)) u_dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_in_instr), .in_pc(a_in_pc), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_opcode(a_out_opcode), .out_rak(a_out_rak), .out_rd(a_out_rd), .out_rs1(a_out_rs1),
        .out_rs2(a_out_rs2), .out_funct3(a_out_funct3), .out_imm(a_out_imm), .out_pc(a_out_pc),
        .out_word(a_out_word), .out_illegal(a_out_illegal)
    );

    decode_stage #(.XLEN(64), .ENABLE_M(0)) u_dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_pc(b_in_pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_opcode(b_out_opcode), .out_rak(b_out_rak), .out_rd(b_out_rd), .out_rs1(b_out_rs1),
        .out_rs2(b_out_rs2), .out_funct3(b_out_funct3), .out_imm(b_out_imm), .out_pc(b_out_pc),
        .out_word(b_out_word), .out_illegal(b_out_illegal)
    );

    function automatic exp_t mk(input opcode_t op, input reg_arith_kind_t rak,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [63:0] imm,
                                input logic word, input logic ill);
        exp_t e;
        e.op = op; e.rak = rak; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.f3 = f3; e.imm = imm; e.pc = 64'h0; e.word = word; e.ill = ill;
        return e;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic cmp_entry(input string name, input exp_t act, input exp_t e, input bit show);
        n_checks++;
        if (act.op !== e.op || act.rak !== e.rak || act.rd !== e.rd || act.rs1 !== e.rs1 ||
            act.rs2 !== e.rs2 || act.f3 !== e.f3 || act.imm !== e.imm || act.pc !== e.pc ||
            act.word !== e.word || act.ill !== e.ill) begin
            n_errors++;
            $display("FAIL %s: got op=%0d rak=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h pc=%h w=%0b ill=%0b required op=%0d rak=%0d rd=%0d rs1=%0d rs2=%0d f3=%0d imm=%h pc=%h w=%0b ill=%0b",
                     name, act.op, act.rak, act.rd, act.rs1, act.rs2, act.f3, act.imm, act.pc, act.word, act.ill,
                     e.op, e.rak, e.rd, e.rs1, e.rs2, e.f3, e.imm, e.pc, e.word, e.ill);
        end else if (show) begin
            $display("%s ok: pc=%h op=%0d rak=%0d rd=%0d rs1=%0d rs2=%0d imm=%h ill=%0b",
                     name, e.pc, e.op, e.rak, e.rd, e.rs1, e.rs2, e.imm, e.ill);
        end
    endtask

    // monitor A: compare on every accepted output, and hold-check while stalled
    always @(negedge clk) begin
        exp_t act;
        if (!a_rst && a_out_valid) begin
            act.op = a_out_opcode; act.rak = a_out_rak; act.rd = a_out_rd; act.rs1 = a_out_rs1;
            act.rs2 = a_out_rs2; act.f3 = a_out_funct3; act.imm = {32'h0, a_out_imm};
            act.pc = {32'h0, a_out_pc}; act.word = a_out_word; act.ill = a_out_illegal;
            if (a_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL A unexpected: out_valid=1 pc=%h with no expected entry", a_out_pc);
            end else if (a_out_ready) begin
                cmp_entry("A pop", act, a_q.pop_front(), 1'b1);
            end else begin
                cmp_entry("A hold", act, a_q[0], 1'b0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t act;
        if (!b_rst && b_out_valid) begin
            act.op = b_out_opcode; act.rak = b_out_rak; act.rd = b_out_rd; act.rs1 = b_out_rs1;
            act.rs2 = b_out_rs2; act.f3 = b_out_funct3; act.imm = b_out_imm;
            act.pc = b_out_pc; act.word = b_out_word; act.ill = b_out_illegal;
            if (b_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL B unexpected: out_valid=1 pc=%h with no expected entry", b_out_pc);
            end else if (b_out_ready) begin
                cmp_entry("B pop", act, b_q.pop_front(), 1'b1);
            end else begin
                cmp_entry("B hold", act, b_q[0], 1'b0);
            end
        end
    end

    task automatic send_a(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        int n;
        n = 0;
        e.pc = {32'h0, pc};
        a_in_valid = 1'b1; a_in_instr = instr; a_in_pc = pc;
        forever begin
            @(negedge clk);
            if (a_in_ready) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            n_checks++; n_errors++;
            $display("FAIL A send timeout: in_ready=%0b required 1", a_in_ready);
        end else begin
            a_q.push_back(e);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] instr, input logic [63:0] pc, input exp_t e);
        int n;
        n = 0;
        e.pc = pc;
        b_in_valid = 1'b1; b_in_instr = instr; b_in_pc = pc;
        forever begin
            @(negedge clk);
            if (b_in_ready) break;
            n++;
            if (n > 50) break;
        end
        if (n > 50) begin
            n_checks++; n_errors++;
            $display("FAIL B send timeout: in_ready=%0b required 1", b_in_ready);
        end else begin
            b_q.push_back(e);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e_c, e_add;
        bit c_taken;
        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1'b0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1'b1;
        e_add = mk(imm_arith_type, rak_add, 5'd1, 5'd0, 5'd0, 3'd0, 64'd5, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset out_valid", a_out_valid, 0);
        check_val("reset in_ready", a_in_ready, 1);
        check_val("reset opcode", a_out_opcode, invalid);
        check_val("reset imm", a_out_imm, 0);
        check_val("reset illegal", a_out_illegal, 0);
        a_rst = 1'b0; b_rst = 1'b0;
        @(posedge clk); #1;

        // first transaction: one cycle from capture to out_valid
        a_out_ready = 1'b1;
        send_a(32'h00500093, 32'h100, e_add);
        check_val("latency out_valid", a_out_valid, 1);
        @(posedge clk); #1;
        check_val("drain out_valid", a_out_valid, 0);

        // back-pressure: two accepted, third held, then drain with no gap
        a_out_ready = 1'b0;
        send_a(32'h40208033, 32'h200, mk(reg_arith_type, rak_sub, 5'd0, 5'd1, 5'd2, 3'd0, 64'd0, 1'b0, 1'b0));
        check_val("one in_ready", a_in_ready, 1);
        send_a(32'h02208133, 32'h204, mk(reg_arith_type, rak_mul, 5'd2, 5'd1, 5'd2, 3'd0, 64'd0, 1'b0, 1'b0));
        check_val("two in_ready", a_in_ready, 0);
        e_c = mk(store_type, rak_invalid, 5'd0, 5'd1, 5'd2, 3'd2, 64'hFFFF_FFFC, 1'b0, 1'b0);
        e_c.pc = 64'h208;
        a_in_valid = 1'b1; a_in_instr = 32'hFE20AE23; a_in_pc = 32'h208;
        repeat (2) begin
            @(negedge clk);
            check_val("held in_ready", a_in_ready, 0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        c_taken = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bit took;
            took = 1'b0;
            @(negedge clk);
            check_val("no gap out_valid", a_out_valid, 1);
            if (a_in_valid && a_in_ready) begin
                a_q.push_back(e_c);
                took = 1'b1; c_taken = 1'b1;
            end
            @(posedge clk); #1;
            if (took) a_in_valid = 1'b0;
        end
        check_val("third accepted", c_taken, 1);
        check_val("after drain out_valid", a_out_valid, 0);

        // flush in TWO with a push offered
        a_out_ready = 1'b0;
        send_a(32'h00500093, 32'h300, e_add);
        send_a(32'h02208133, 32'h304, mk(reg_arith_type, rak_mul, 5'd2, 5'd1, 5'd2, 3'd0, 64'd0, 1'b0, 1'b0));
        a_in_valid = 1'b1; a_in_instr = 32'h0000007F; a_in_pc = 32'h308; a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_q.delete();
        check_val("flush2 out_valid", a_out_valid, 0);
        check_val("flush2 in_ready", a_in_ready, 1);

        // flush in ONE where the push handshakes in the same cycle
        send_a(32'h00500093, 32'h310, e_add);
        a_in_valid = 1'b1; a_in_instr = 32'h800002B7; a_in_pc = 32'h314; a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_q.delete();
        check_val("flush1 out_valid", a_out_valid, 0);
        check_val("flush1 in_ready", a_in_ready, 1);
        a_out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("flushed entry absent", a_out_valid, 0);
        end
        @(posedge clk); #1;

        // streaming decode vectors, XLEN=32 / ENABLE_M=1
        send_a(32'h800002B7, 32'h400, mk(lui_type, rak_invalid, 5'd5, 5'd0, 5'd0, 3'd0, 64'h8000_0000, 1'b0, 1'b0));
        send_a(32'h0000009B, 32'h404, mk(invalid, rak_invalid, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 1'b0, 1'b1));
        send_a(32'h02009093, 32'h408, mk(invalid, rak_invalid, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 1'b0, 1'b1));
        send_a(32'h0000007F, 32'h40C, mk(invalid, rak_invalid, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 1'b0, 1'b1));
        send_a(32'h80208063, 32'h410, mk(branch_type, rak_invalid, 5'd0, 5'd1, 5'd2, 3'd0, 64'hFFFF_F000, 1'b0, 1'b0));
        send_a(32'h41F1D193, 32'h414, mk(imm_arith_type, rak_sra, 5'd3, 5'd3, 5'd0, 3'd5, 64'h41F, 1'b0, 1'b0));
        send_a(32'hFFFFF06F, 32'h418, mk(jal_type, rak_invalid, 5'd0, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFE, 1'b0, 1'b0));
        send_a(32'h02208133, 32'h41C, mk(reg_arith_type, rak_mul, 5'd2, 5'd1, 5'd2, 3'd0, 64'd0, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #1;

        // asynchronous reset between edges while in ONE
        a_out_ready = 1'b0;
        send_a(32'h00500093, 32'h500, e_add);
        #3 a_rst = 1'b1;
        #1;
        check_val("async rst out_valid", a_out_valid, 0);
        check_val("async rst in_ready", a_in_ready, 1);
        check_val("async rst opcode", a_out_opcode, invalid);
        check_val("async rst imm", a_out_imm, 0);
        check_val("async rst pc", a_out_pc, 0);
        a_q.delete();
        a_in_valid = 1'b1; a_in_instr = 32'h00500093; a_in_pc = 32'h504;
        repeat (2) @(posedge clk);
        #1;
        a_in_valid = 1'b0; a_rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst ignores in_valid", a_out_valid, 0);

        // instance B: XLEN=64, ENABLE_M=0
        send_b(32'hFFF00093, 64'h8000_0000_0000_0000, mk(imm_arith_type, rak_add, 5'd1, 5'd0, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0));
        send_b(32'h02208133, 64'h8000_0000_0000_0004, mk(invalid, rak_invalid, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0, 1'b0, 1'b1));
        send_b(32'h0000009B, 64'h8000_0000_0000_0008, mk(imm_arith_type, rak_add, 5'd1, 5'd0, 5'd0, 3'd0, 64'd0, 1'b1, 1'b0));
        send_b(32'h4020803B, 64'h8000_0000_0000_000C, mk(reg_arith_type, rak_sub, 5'd0, 5'd1, 5'd2, 3'd0, 64'd0, 1'b1, 1'b0));
        send_b(32'h02009093, 64'h8000_0000_0000_0010, mk(imm_arith_type, rak_sll, 5'd1, 5'd1, 5'd0, 3'd1, 64'd32, 1'b0, 1'b0));

        for (int k = 0; k < 20; k++) begin
            if (a_q.size() == 0 && b_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check_val("A queue drained", a_q.size(), 0);
        check_val("B queue drained", b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
